// File: rtl/branch_resolve_if.sv
// rtl/branch_resolve_if.sv - resolved-branch request/response bundle between execute and the redirect logic
interface branch_resolve_if #(
  parameter int TAG_W = 4
) ();
  logic             InValid;
  logic             InReady;
  logic [2:0]       Funct3;
  logic [1:0]       Flags;
  logic             PredTaken;
  logic [TAG_W-1:0] Tag;
  logic             Sgnd;
  logic             OutValid;
  logic             OutReady;
  logic             OutTaken;
  logic             OutMispredict;
  logic             OutIllegal;
  logic [TAG_W-1:0] OutTag;

  modport master (
    output InValid, Funct3, Flags, PredTaken, Tag, OutReady,
    input  InReady, Sgnd, OutValid, OutTaken, OutMispredict, OutIllegal, OutTag
  );

  modport slave (
    input  InValid, Funct3, Flags, PredTaken, Tag, OutReady,
    output InReady, Sgnd, OutValid, OutTaken, OutMispredict, OutIllegal, OutTag
  );
endinterface

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - branch direction resolve, mispredict check and result queue (BRANCH_RESOLVE_PERF_EN adds perf counters)
module branch_resolve #(
  parameter int TAG_W = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Flush,
  branch_resolve_if.slave  bus,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] MispredCount
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] taken_q;
  logic [DEPTH-1:0] mis_q;
  logic [DEPTH-1:0] ill_q;
  logic [TAG_W-1:0] tag_q [DEPTH];

  logic eq;
  logic lt;
  logic taken;
  logic illegal;
  logic mispredict;
  logic push;
  logic pop;

  assign eq = bus.Flags[1];
  assign lt = bus.Flags[0];

  // Unsigned compares are the funct3 codes with bit 1 set (BLTU/BGEU).
  assign bus.Sgnd = ~bus.Funct3[1];

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (bus.Funct3)
      3'b000:         taken = eq;
      3'b001:         taken = ~eq;
      3'b100, 3'b110: taken = lt;
      3'b101, 3'b111: taken = ~lt;
      default:        illegal = 1'b1;
    endcase
  end

  assign mispredict = ~illegal & (taken ^ bus.PredTaken);

  // InReady depends only on registered count, never on OutReady.
  assign bus.InReady  = (count < FULL);
  assign bus.OutValid = (count != '0);

  assign push = bus.InValid & bus.InReady;
  assign pop  = bus.OutValid & bus.OutReady;

  assign bus.OutTaken      = taken_q[rd_ptr];
  assign bus.OutMispredict = mis_q[rd_ptr];
  assign bus.OutIllegal    = ill_q[rd_ptr];
  assign bus.OutTag        = tag_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      taken_q <= '0;
      mis_q   <= '0;
      ill_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
      end
    end else if (Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        taken_q[wr_ptr] <= taken;
        mis_q[wr_ptr]   <= mispredict;
        ill_q[wr_ptr]   <= illegal;
        tag_q[wr_ptr]   <= bus.Tag;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef BRANCH_RESOLVE_PERF_EN
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  // Counts follow the pop handshake, so a pop in a flush cycle still counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (pop && !bus.OutIllegal) begin
      branch_cnt <= branch_cnt + CNT_W'(1);
      if (bus.OutMispredict) begin
        mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
    end
  end

  assign BranchCount  = branch_cnt;
  assign MispredCount = mispred_cnt;
`else
  assign BranchCount  = '0;
  assign MispredCount = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - directed table-driven bench for branch_resolve
module tb_branch_resolve;

  localparam int TAG_W = 4;
  localparam int DEPTH = 2;
  localparam int CNT_W = 32;

  logic clk;
  logic reset;
  logic Flush;
  logic [CNT_W-1:0] BranchCount;
  logic [CNT_W-1:0] MispredCount;

  branch_resolve_if #(.TAG_W(TAG_W)) bus ();

  branch_resolve #(.TAG_W(TAG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .Flush        (Flush),
    .bus          (bus),
    .BranchCount  (BranchCount),
    .MispredCount (MispredCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       f3;
    logic [1:0]       fl;
    logic             pred;
    logic [TAG_W-1:0] tag;
    logic             sgnd;
    logic             taken;
    logic             mis;
    logic             ill;
  } vec_t;

  vec_t vecs [9];

  int checks;
  int errors;
  int exp_bc;
  int exp_mc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_counters(input string name);
`ifdef BRANCH_RESOLVE_PERF_EN
    check({name, "_bc"}, BranchCount, 32'(exp_bc));
    check({name, "_mc"}, MispredCount, 32'(exp_mc));
`else
    check({name, "_bc"}, BranchCount, 32'd0);
    check({name, "_mc"}, MispredCount, 32'd0);
`endif
  endtask

  task automatic drive(input logic v, input logic [2:0] f3, input logic [1:0] fl,
                       input logic pred, input logic [TAG_W-1:0] tag);
    bus.InValid   = v;
    bus.Funct3    = f3;
    bus.Flags     = fl;
    bus.PredTaken = pred;
    bus.Tag       = tag;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic account(input vec_t v);
    if (!v.ill) begin
      exp_bc++;
      if (v.mis) exp_mc++;
    end
  endtask

  initial begin
    vec_t beq_hit;
    vec_t beq_miss;
    checks = 0;
    errors = 0;
    exp_bc = 0;
    exp_mc = 0;

    //            f3      fl     pred  tag  sgnd taken mis  ill
    vecs[0] = '{3'b000, 2'b10, 1'b0, 4'd3,  1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{3'b101, 2'b01, 1'b0, 4'd4,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{3'b100, 2'b01, 1'b1, 4'd5,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{3'b110, 2'b00, 1'b1, 4'd6,  1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{3'b001, 2'b10, 1'b1, 4'd7,  1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{3'b111, 2'b00, 1'b1, 4'd8,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{3'b010, 2'b11, 1'b1, 4'd9,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{3'b011, 2'b00, 1'b0, 4'd10, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{3'b001, 2'b00, 1'b1, 4'd11, 1'b1, 1'b1, 1'b0, 1'b0};
    beq_hit  = '{3'b000, 2'b10, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    beq_miss = '{3'b000, 2'b10, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0};

    reset = 1'b1;
    Flush = 1'b0;
    bus.OutReady = 1'b0;
    drive(1'b0, 3'b000, 2'b00, 1'b0, '0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_outvalid", bus.OutValid, 0);
    check("rst_inready", bus.InReady, 1);
    check("rst_taken", bus.OutTaken, 0);
    check("rst_mis", bus.OutMispredict, 0);
    check("rst_ill", bus.OutIllegal, 0);
    check("rst_tag", bus.OutTag, 0);
    check_counters("rst");

    // Decode sweep: one push per cycle, drained every cycle.
    bus.OutReady = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, vecs[i].f3, vecs[i].fl, vecs[i].pred, vecs[i].tag);
      #1;
      check($sformatf("sgnd_%0d", i), bus.Sgnd, vecs[i].sgnd);
      if (i > 0) account(vecs[i-1]);
      tick();
      check($sformatf("valid_%0d", i), bus.OutValid, 1);
      check($sformatf("taken_%0d", i), bus.OutTaken, vecs[i].taken);
      check($sformatf("mis_%0d", i), bus.OutMispredict, vecs[i].mis);
      check($sformatf("ill_%0d", i), bus.OutIllegal, vecs[i].ill);
      check($sformatf("tag_%0d", i), bus.OutTag, vecs[i].tag);
      check_counters($sformatf("sweep_%0d", i));
    end
    drive(1'b0, 3'b000, 2'b00, 1'b0, '0);
    account(vecs[8]);
    tick();
    check("sweep_drained", bus.OutValid, 0);
    check("sweep_inready", bus.InReady, 1);
    check_counters("sweep_end");

    // Backpressure: fill both entries, third push must be refused.
    bus.OutReady = 1'b0;
    drive(1'b1, beq_hit.f3, beq_hit.fl, beq_hit.pred, 4'd1);
    tick();
    drive(1'b1, beq_hit.f3, beq_hit.fl, beq_hit.pred, 4'd2);
    tick();
    check("bp_full_inready", bus.InReady, 0);
    check("bp_full_valid", bus.OutValid, 1);
    drive(1'b1, beq_hit.f3, beq_hit.fl, beq_hit.pred, 4'd3);
    tick();
    drive(1'b0, 3'b000, 2'b00, 1'b0, '0);
    check("bp_hold_tag", bus.OutTag, 1);
    check("bp_hold_inready", bus.InReady, 0);
    bus.OutReady = 1'b1;
    account(beq_hit);
    tick();
    check("bp_pop2_valid", bus.OutValid, 1);
    check("bp_pop2_tag", bus.OutTag, 2);
    check("bp_pop2_inready", bus.InReady, 1);
    account(beq_hit);
    tick();
    check("bp_empty", bus.OutValid, 0);
    check_counters("bp");

    // Simultaneous push/pop at count 1, walking pointers through several wraps.
    drive(1'b1, beq_miss.f3, beq_miss.fl, beq_miss.pred, 4'd1);
    tick();
    for (int k = 2; k <= 6; k++) begin
      drive(1'b1, beq_miss.f3, beq_miss.fl, beq_miss.pred, 4'(k));
      account(beq_miss);
      tick();
      check($sformatf("pp_valid_%0d", k), bus.OutValid, 1);
      check($sformatf("pp_inready_%0d", k), bus.InReady, 1);
      check($sformatf("pp_tag_%0d", k), bus.OutTag, 32'(k));
      check($sformatf("pp_mis_%0d", k), bus.OutMispredict, 1);
    end
    drive(1'b0, 3'b000, 2'b00, 1'b0, '0);
    account(beq_miss);
    tick();
    check("pp_drained", bus.OutValid, 0);
    check_counters("pp");

    // Flush with two queued entries, a concurrent push and a handshaking pop.
    bus.OutReady = 1'b0;
    drive(1'b1, beq_miss.f3, beq_miss.fl, beq_miss.pred, 4'd7);
    tick();
    drive(1'b1, beq_hit.f3, beq_hit.fl, beq_hit.pred, 4'd8);
    tick();
    check("fl_full", bus.InReady, 0);
    drive(1'b1, beq_hit.f3, beq_hit.fl, beq_hit.pred, 4'd9);
    Flush = 1'b1;
    bus.OutReady = 1'b1;
    account(beq_miss);
    tick();
    Flush = 1'b0;
    drive(1'b0, 3'b000, 2'b00, 1'b0, '0);
    check("fl_valid", bus.OutValid, 0);
    check("fl_inready", bus.InReady, 1);
    check_counters("fl");
    tick();
    check("fl_stays_empty", bus.OutValid, 0);
    drive(1'b1, vecs[3].f3, vecs[3].fl, vecs[3].pred, 4'd12);
    bus.OutReady = 1'b0;
    tick();
    drive(1'b0, 3'b000, 2'b00, 1'b0, '0);
    check("postfl_valid", bus.OutValid, 1);
    check("postfl_tag", bus.OutTag, 12);
    check("postfl_mis", bus.OutMispredict, 1);

    // Reset mid-stream discards the queue and clears counters.
    drive(1'b1, beq_hit.f3, beq_hit.fl, beq_hit.pred, 4'd13);
    tick();
    drive(1'b0, 3'b000, 2'b00, 1'b0, '0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_bc = 0;
    exp_mc = 0;
    check("rst2_valid", bus.OutValid, 0);
    check("rst2_inready", bus.InReady, 1);
    check("rst2_tag", bus.OutTag, 0);
    check("rst2_taken", bus.OutTaken, 0);
    check_counters("rst2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end

endmodule
